// File: rtl/f1_lights_seq_if.sv
// Bundle of the light sequencer's control inputs and display/timing outputs.
interface f1_lights_seq_if #(
  parameter int unsigned NUM_LIGHTS = 8,
  parameter int unsigned RT_WIDTH   = 16
);
  logic                  en;
  logic [15:0]           N;
  logic                  trigger;
  logic [7:0]            delay;
  logic                  react;
  logic [NUM_LIGHTS-1:0] data_out;
  logic                  busy;
  logic [RT_WIDTH-1:0]   time_out;
  logic                  time_valid;
  logic                  false_start;

  // Stimulus side: drives controls, observes lamps and timing.
  modport master (
    output en, N, trigger, delay, react,
    input  data_out, busy, time_out, time_valid, false_start
  );

  // Sequencer side.
  modport slave (
    input  en, N, trigger, delay, react,
    output data_out, busy, time_out, time_valid, false_start
  );
endinterface

// File: rtl/f1_lights_seq.sv
// F1 start-light sequencer with tick divider, programmable hold and reaction timer.
// Optional feature macro: LFSR_DELAY_EN (random hold length = LFSR & delay).
module f1_lights_seq #(
  parameter int unsigned NUM_LIGHTS = 8,
  parameter int unsigned RT_WIDTH   = 16
) (
  input  logic           clk,
  input  logic           rst,
  f1_lights_seq_if.slave bus
);

  localparam int unsigned DIV_W  = 16;
  localparam int unsigned HOLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_TIMING = 2'd3
  } state_t;

  state_t                state_q;
  logic [DIV_W-1:0]      div_q;
  logic [DIV_W-1:0]      n_q;
  logic [HOLD_W-1:0]     hold_q;
  logic [RT_WIDTH-1:0]   rt_q;
  logic [NUM_LIGHTS-1:0] data_q;
  logic [RT_WIDTH-1:0]   time_q;
  logic                  valid_q;
  logic                  fs_q;
  logic                  busy_q;

  logic                  tick;
  logic                  fill_done;
  logic [HOLD_W-1:0]     hold_load;
  logic [RT_WIDTH-1:0]   rt_inc;

  // Divider tick: only counts outside IDLE and only on enabled cycles.
  assign tick = (state_q != ST_IDLE) && bus.en && (div_q == DIV_W'(0));

  // Next shift fills the last lamp when all lower lamps are already lit.
  assign fill_done = &data_q[NUM_LIGHTS-2:0];

  // Saturating increment; also the captured value, so the reported time counts
  // cycles from the lights-out cycle up to and including the react cycle.
  assign rt_inc = (rt_q == {RT_WIDTH{1'b1}}) ? rt_q : rt_q + RT_WIDTH'(1);

`ifdef LFSR_DELAY_EN
  logic [7:0] lfsr_q;
  logic       lfsr_fb;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Free-running maximal LFSR, x^8+x^6+x^5+x^4+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
    end
  end

  assign hold_load = lfsr_q & bus.delay;
`else
  assign hold_load = bus.delay;
`endif

  // Sequencer FSM, divider, hold counter and reaction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      n_q     <= '0;
      hold_q  <= '0;
      rt_q    <= '0;
      data_q  <= '0;
      time_q  <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      if ((state_q != ST_IDLE) && bus.en) begin
        div_q <= (div_q == DIV_W'(0)) ? n_q : div_q - DIV_W'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (bus.trigger) begin
            state_q <= ST_FILL;
            div_q   <= bus.N;
            n_q     <= bus.N;
            data_q  <= '0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        ST_FILL: begin
          if (bus.react) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            fs_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tick) begin
            data_q <= {data_q[NUM_LIGHTS-2:0], 1'b1};
            if (fill_done) begin
              state_q <= ST_HOLD;
              hold_q  <= hold_load;
            end
          end
        end

        ST_HOLD: begin
          if (bus.react) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            fs_q    <= 1'b1;
            busy_q  <= 1'b0;
          end else if (tick) begin
            if (hold_q == HOLD_W'(0)) begin
              state_q <= ST_TIMING;
              data_q  <= '0;
              rt_q    <= '0;
            end else begin
              hold_q <= hold_q - HOLD_W'(1);
            end
          end
        end

        ST_TIMING: begin
          if (bus.react) begin
            state_q <= ST_IDLE;
            time_q  <= rt_inc;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            rt_q <= rt_inc;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data_out    = data_q;
  assign bus.busy        = busy_q;
  assign bus.time_out    = time_q;
  assign bus.time_valid  = valid_q;
  assign bus.false_start = fs_q;

endmodule
